n_s_acq_seq: RTL and testbench
==============================

Name: n_s_acq_seq

Overview:
Acquisition sequencer on the consumer side of the noise/signal path switch. It drives n_s_ctrl to select the noise path and then the signal path. During each phase it captures the merged 16-bit sample stream returned through the switch. Each captured sample is tagged with its phase, buffered in a small FIFO and delivered downstream over a valid/ready handshake to the echo-processing/telemetry logic.

Parameters:
SETTLE_CYC, 8, clk cycles after each n_s_ctrl change during which strobes are ignored (range 1..255)
FIFO_DEPTH, 16, output FIFO entries (power of two, ≥ 2)
CNT_W, 16, width of the sample-count inputs

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a noise+signal acquisition run
n_count  in  CNT_W  noise samples per run; sampled on accepted start
s_count  in  CNT_W  signal samples per run; sampled on accepted start
n_s_ctrl  out  1  path select to the switch: 1 = noise path, 0 = signal path
dataout  in  16  merged sample from the switch
data_strobe  in  1  one-cycle sample-valid pulse, already in clk domain
out_data  out  16  FIFO head sample
out_tag  out  1  phase of the head sample: 1 = noise, 0 = signal
out_valid  out  1  FIFO not empty
out_ready  in  1  downstream accepts the head when high together with out_valid
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at run completion
overflow  out  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset values:
  - n_s_ctrl = 0, out_valid = 0, out_data = 0, out_tag = 0, busy = 0, done = 0, overflow = 0.
  - FIFO is emptied, FSM goes to IDLE, all counters are cleared.
- Reset asserted mid-run aborts the run immediately. No done pulse is produced and buffered samples are discarded.
- FSM states: IDLE, N_SETTLE, N_ACQ, S_SETTLE, S_ACQ, FLUSH, DONE.
- IDLE:
  - On start: latch n_count and s_count, clear overflow.
  - Go to N_SETTLE if n_count ≠ 0. Otherwise go to S_SETTLE if s_count ≠ 0. Otherwise go directly to DONE.
- start is ignored in every state other than IDLE.
- N_SETTLE: n_s_ctrl = 1. Stay exactly SETTLE_CYC cycles, ignoring data_strobe, then go to N_ACQ.
- N_ACQ: n_s_ctrl = 1. Each data_strobe pushes {tag=1, dataout} and increments the sample counter. On the strobe that brings the count to n_count, go to S_SETTLE if s_count ≠ 0, else go to FLUSH.
- S_SETTLE / S_ACQ: same as the noise phase but with n_s_ctrl = 0 and tag = 0. On the final signal strobe, go to FLUSH.
- n_s_ctrl changes only on the transition into N_SETTLE or S_SETTLE. It returns to 0 on entering FLUSH and holds 0 in IDLE.
- FLUSH: wait until the FIFO is empty, then go to DONE.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- FIFO:
  - Write is registered. A strobe in cycle t makes the sample visible as out_valid/out_data in cycle t+1 when the FIFO was empty.
  - Read is show-ahead: out_data and out_tag are valid whenever out_valid = 1 and hold stable until popped.
  - Pop happens when out_valid && out_ready.
- FIFO full:
  - A strobe with no pop in the same cycle drops the sample and sets overflow.
  - The dropped strobe still counts toward n_count/s_count, so phase timing is independent of downstream backpressure.
  - Push and pop in the same cycle when full are both accepted, with no overflow.
- FIFO empty: out_valid = 0 and out_ready is ignored.
- Samples that are in flight across a phase boundary keep the tag of the phase in which they were strobed.
- Counter widths: sample counter is CNT_W bits and compares for equality with the latched count (no wrap). Settle counter is 8 bits.

Decomposition:
- Shared package nsa_pkg:
  - FSM state enum (state_t).
  - TAG_NOISE = 1'b1, TAG_SIGNAL = 1'b0.
  - Localparam PTR_W = $clog2(FIFO_DEPTH).
- Sub-module nsa_fifo:
  - Synchronous show-ahead FIFO, 17 bits wide (tag + data), FIFO_DEPTH deep.
  - Ports: push, pop, full, empty.
  - Uses an extra pointer bit to distinguish full from empty.
- The top level holds the FSM, the counters and the overflow logic.

Test Plan:
1. Basic run: n_count = 3, s_count = 2, out_ready = 1, one strobe every 4 cycles with data 0x0001..0x0005.
   - Expect n_s_ctrl high for SETTLE_CYC + capture time.
   - Outputs in order: 0x0001, 0x0002, 0x0003 with tag 1, then 0x0004, 0x0005 with tag 0.
   - Expect one done pulse, overflow = 0.
2. Settle masking: strobes during N_SETTLE and S_SETTLE carrying 0xDEAD.
   - Expect no 0xDEAD on out_data and exact sample counts.
3. Backpressure: FIFO_DEPTH = 16, n_count = 20, out_ready = 0.
   - Expect 16 samples retained, overflow = 1.
   - Raise out_ready: the first 16 values drain in order, then done fires.
4. Zero counts:
   - n_count = 0, s_count = 2: n_s_ctrl never goes high, 2 samples with tag 0.
   - Both counts 0: done arrives 2 cycles after start, with no samples.
5. Start while busy and full-boundary push+pop:
   - A second start during N_ACQ is ignored.
   - With the FIFO full, a strobe coinciding with a pop is accepted and overflow stays 0.
6. Mid-run reset: assert rst during S_ACQ.
   - Next cycle: n_s_ctrl = 0, out_valid = 0, busy = 0, no done pulse.
   - A subsequent start runs normally.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared types and constants for the noise/signal acquisition sequencer.
package nsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    N_SETTLE,
    N_ACQ,
    S_SETTLE,
    S_ACQ,
    FLUSH,
    DONE
  } state_t;

  localparam logic TAG_NOISE  = 1'b1;
  localparam logic TAG_SIGNAL = 1'b0;

  localparam int DEF_FIFO_DEPTH = 16;
  localparam int PTR_W          = $clog2(DEF_FIFO_DEPTH);

  typedef struct packed {
    logic        tag;
    logic [15:0] dat;
  } sample_t;

endpackage

// File: rtl/nsa_fifo.sv
// Show-ahead sample FIFO: a write becomes visible the cycle after push.
// Full/empty come from an extra pointer wrap bit; head reads as zero when empty.
module nsa_fifo
  import nsa_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  sample_t wdat,
  output sample_t rdat,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  sample_t         mem_q [DEPTH];
  logic [AW:0]     wr_q;
  logic [AW:0]     rd_q;
  logic            do_push;
  logic            do_pop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdat;
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdat  = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/n_s_acq_seq.sv
// Noise/signal acquisition sequencer: settles the switch, captures tagged samples, drains via FIFO.
// Samples appear one cycle after their strobe; a full FIFO drops samples (sticky overflow) without stalling the phase.
module n_s_acq_seq
  import nsa_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_count,
  input  logic [CNT_W-1:0] s_count,
  output logic             n_s_ctrl,
  input  logic [15:0]      dataout,
  input  logic             data_strobe,
  output logic [15:0]      out_data,
  output logic             out_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] n_cnt_q;
  logic [CNT_W-1:0] s_cnt_q;
  logic [CNT_W-1:0] samp_q;
  logic [CNT_W-1:0] samp_d;
  logic [7:0]       settle_q;
  logic             ctrl_q;
  logic             done_q;
  logic             ovf_q;

  logic    acq_n;
  logic    acq_s;
  logic    push_req;
  logic    pop;
  logic    full;
  logic    empty;
  sample_t wdat;
  sample_t rdat;

  assign acq_n    = (state_q == N_ACQ) && data_strobe;
  assign acq_s    = (state_q == S_ACQ) && data_strobe;
  assign push_req = acq_n || acq_s;
  assign pop      = !empty && out_ready;
  assign samp_d   = samp_q + CNT_W'(1);
  assign wdat     = '{tag: acq_n ? TAG_NOISE : TAG_SIGNAL, dat: dataout};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_cnt_q  <= '0;
      s_cnt_q  <= '0;
      samp_q   <= '0;
      settle_q <= '0;
      ctrl_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push_req && full && !pop) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            n_cnt_q  <= n_count;
            s_cnt_q  <= s_count;
            ovf_q    <= 1'b0;
            samp_q   <= '0;
            settle_q <= '0;
            if (n_count != '0) begin
              state_q <= N_SETTLE;
              ctrl_q  <= 1'b1;
            end else if (s_count != '0) begin
              state_q <= S_SETTLE;
            end else begin
              state_q <= DONE;
            end
          end
        end
        N_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_q <= N_ACQ;
          else                         settle_q <= settle_q + 8'd1;
        end
        N_ACQ: begin
          // Dropped strobes still count so phase length ignores backpressure.
          if (data_strobe) begin
            samp_q <= samp_d;
            if (samp_d == n_cnt_q) begin
              samp_q   <= '0;
              settle_q <= '0;
              ctrl_q   <= 1'b0;
              state_q  <= (s_cnt_q != '0) ? S_SETTLE : FLUSH;
            end
          end
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_q <= S_ACQ;
          else                         settle_q <= settle_q + 8'd1;
        end
        S_ACQ: begin
          if (data_strobe) begin
            samp_q <= samp_d;
            if (samp_d == s_cnt_q) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          ctrl_q <= 1'b0;
          if (empty) state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  nsa_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdat  (wdat),
    .rdat  (rdat),
    .full  (full),
    .empty (empty)
  );

  assign n_s_ctrl  = ctrl_q;
  assign out_data  = rdat.dat;
  assign out_tag   = rdat.tag;
  assign out_valid = !empty;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_n_s_acq_seq.sv
// Directed bench for n_s_acq_seq: stimulus queues expected samples, a monitor pops and compares on each handshake.
module tb_n_s_acq_seq;
  import nsa_pkg::*;

  localparam int SETTLE = 8;
  localparam int DEPTH  = 16;
  localparam int CW     = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] n_count;
  logic [CW-1:0] s_count;
  logic          n_s_ctrl;
  logic [15:0]   dataout;
  logic          data_strobe;
  logic [15:0]   out_data;
  logic          out_tag;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          overflow;

  int          total    = 0;
  int          bad      = 0;
  int          done_cnt = 0;
  int          ns_hi    = 0;
  logic [16:0] sb[$];
  logic [16:0] exp_e;
  logic [15:0] nxt      = 16'd1;

  always #5 clk = ~clk;

  n_s_acq_seq #(
    .SETTLE_CYC(SETTLE),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_count    (n_count),
    .s_count    (s_count),
    .n_s_ctrl   (n_s_ctrl),
    .dataout    (dataout),
    .data_strobe(data_strobe),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (n_s_ctrl) ns_hi++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", {15'd0, out_tag, out_data}, 32'hFFFF_FFFF);
        end else begin
          exp_e = sb.pop_front();
          check("pop", {15'd0, out_tag, out_data}, {15'd0, exp_e});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n, input int s);
    start   = 1'b1;
    n_count = 16'(n);
    s_count = 16'(s);
    ns_hi   = 0;
    tick;
    start   = 1'b0;
  endtask

  task automatic settle_wait(input bit junk);
    repeat (SETTLE) begin
      data_strobe = junk;
      dataout     = 16'hDEAD;
      tick;
    end
    data_strobe = 1'b0;
  endtask

  task automatic strobe(input logic tag, input int gap, input bit keep);
    data_strobe = 1'b1;
    dataout     = nxt;
    if (keep) sb.push_back({tag, nxt});
    nxt++;
    tick;
    data_strobe = 1'b0;
    repeat (gap) tick;
  endtask

  task automatic phase(input logic tag, input int cnt, input int gap, input bit junk);
    if (cnt > 0) begin
      settle_wait(junk);
      for (int i = 0; i < cnt; i++) strobe(tag, (i == cnt - 1) ? 0 : gap, 1'b1);
    end
  endtask

  task automatic wait_done(input int bound);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    check("done_seen", done_cnt - d0, 1);
    repeat (3) tick;
    check("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int          d0;
    logic [15:0] base;
    rst = 1'b1; start = 1'b0; data_strobe = 1'b0; out_ready = 1'b0;
    dataout = '0; n_count = '0; s_count = '0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check("rst_ctrl", n_s_ctrl, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_tag", out_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);

    // 1: basic run, strobe every 4 cycles, data 1..5
    out_ready = 1'b1;
    pulse_start(3, 2);
    check("t1_busy", busy, 1);
    check("t1_ctrl", n_s_ctrl, 1);
    phase(TAG_NOISE, 3, 3, 1'b0);
    check("t1_ctrl_sig", n_s_ctrl, 0);
    phase(TAG_SIGNAL, 2, 3, 1'b0);
    wait_done(100);
    check("t1_ns_hi", ns_hi, SETTLE + 9);
    check("t1_ovf", overflow, 0);
    check("t1_sb", sb.size(), 0);

    // 2: 0xDEAD strobes throughout both settle windows
    pulse_start(2, 3);
    phase(TAG_NOISE, 2, 1, 1'b1);
    phase(TAG_SIGNAL, 3, 1, 1'b1);
    wait_done(100);
    check("t2_ns_hi", ns_hi, SETTLE + 3);
    check("t2_sb", sb.size(), 0);

    // 3: backpressure, 20 strobes into a 16-deep FIFO
    out_ready = 1'b0;
    base = nxt;
    pulse_start(20, 0);
    settle_wait(1'b0);
    for (int i = 0; i < 20; i++) strobe(TAG_NOISE, 0, i < DEPTH);
    check("t3_ovf", overflow, 1);
    check("t3_valid", out_valid, 1);
    check("t3_head", out_data, base);
    check("t3_busy", busy, 1);
    out_ready = 1'b1;
    wait_done(200);
    check("t3_ovf_sticky", overflow, 1);
    check("t3_sb", sb.size(), 0);

    // 4a: noise count zero
    pulse_start(0, 2);
    check("t4_ovf_clr", overflow, 0);
    phase(TAG_SIGNAL, 2, 2, 1'b0);
    wait_done(100);
    check("t4_ns_hi", ns_hi, 0);
    check("t4_sb", sb.size(), 0);

    // 4b: both counts zero, done two cycles after start
    pulse_start(0, 0);
    check("t4b_done_c1", done, 0);
    check("t4b_busy_c1", busy, 1);
    tick;
    check("t4b_done_c2", done, 1);
    tick;
    check("t4b_done_c3", done, 0);
    check("t4b_busy_c3", busy, 0);

    // 5a: second start during N_ACQ must be ignored
    pulse_start(2, 1);
    settle_wait(1'b0);
    strobe(TAG_NOISE, 1, 1'b1);
    start = 1'b1; n_count = 16'd5; s_count = 16'd5;
    tick;
    start = 1'b0;
    check("t5_busy", busy, 1);
    check("t5_ctrl", n_s_ctrl, 1);
    strobe(TAG_NOISE, 0, 1'b1);
    phase(TAG_SIGNAL, 1, 0, 1'b0);
    wait_done(100);
    check("t5_ns_hi", ns_hi, SETTLE + 4);

    // 5b: push coinciding with pop while full
    out_ready = 1'b0;
    base = nxt;
    pulse_start(17, 0);
    settle_wait(1'b0);
    for (int i = 0; i < DEPTH; i++) strobe(TAG_NOISE, 0, 1'b1);
    out_ready = 1'b1;
    strobe(TAG_NOISE, 0, 1'b1);
    out_ready = 1'b0;
    check("t5b_ovf", overflow, 0);
    check("t5b_valid", out_valid, 1);
    check("t5b_head", out_data, base + 16'd1);
    out_ready = 1'b1;
    wait_done(100);
    check("t5b_ovf_end", overflow, 0);
    check("t5b_sb", sb.size(), 0);

    // 6: reset during S_ACQ
    out_ready = 1'b0;
    pulse_start(1, 3);
    phase(TAG_NOISE, 1, 0, 1'b0);
    settle_wait(1'b0);
    strobe(TAG_SIGNAL, 1, 1'b1);
    check("t6_busy_pre", busy, 1);
    rst = 1'b1;
    tick;
    check("t6_ctrl", n_s_ctrl, 0);
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    rst = 1'b0;
    sb.delete();
    d0 = done_cnt;
    repeat (20) tick;
    check("t6_no_done", done_cnt - d0, 0);
    out_ready = 1'b1;
    pulse_start(1, 1);
    phase(TAG_NOISE, 1, 0, 1'b0);
    phase(TAG_SIGNAL, 1, 0, 1'b0);
    wait_done(100);
    check("t6_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
